// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin select arbiter: FSM encoding and
// default sizing.
package arb_pkg;

  localparam int unsigned N_DEF        = 8;
  localparam int unsigned SEL_W_DEF    = 3;
  localparam int unsigned HOLD_MAX_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    REL   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/decoder.sv
// Plain SEL_W-to-N one-hot decoder driven by the shared select bus.
module decoder #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned N     = 8
) (
  input  logic [SEL_W-1:0] s,
  output logic [N-1:0]     y
);

  // One-hot expansion of the select value.
  always_comb begin
    y    = '0;
    y[s] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_arbiter_pick.sv
// Round-robin search: first set request strictly after `last`, wrapping,
// with `last` itself examined at the very end of the wrap.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest set bit wins; the
  // offset is truncated to SEL_W bits so the sum wraps modulo N by itself.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = N; i >= 1; i--) begin
      cand = last + SEL_W'(i);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter owning the decoder select lines for N requesters.
// Grant is held until release, followed by one mandatory dead cycle.
// Optional forced release after HOLD_MAX cycles: RR_DECODE_ARBITER_TIMEOUT_EN.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned SEL_W    = SEL_W_DEF,
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N-1:0]     gnt,
  output logic             valid,
  output logic             timeout
);

  if (N != (1 << SEL_W)) begin : g_bad_n
    $error("rr_decode_arbiter: N must equal 2**SEL_W");
  end
  if (HOLD_MAX == 0) begin : g_bad_hold
    $error("rr_decode_arbiter: HOLD_MAX must be nonzero");
  end

  arb_state_e       state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic             valid_q;
  logic             timeout_q;
  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic [N-1:0]     dec_y;
  logic             hold_limit;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  decoder #(
    .SEL_W (SEL_W),
    .N     (N)
  ) u_dec (
    .s (sel_q),
    .y (dec_y)
  );

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  localparam int unsigned HW = $clog2(HOLD_MAX + 1);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;

  assign hold_d     = hold_q + HW'(1);
  assign hold_limit = (hold_d == HW'(HOLD_MAX));

  // Grant-length counter: zero outside GRANT, counts each GRANT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (state_q != GRANT) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign hold_limit = 1'b0;
`endif

  // Arbitration FSM; every output is a register so reset clears them at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= '1;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
            sel_q   <= pick_idx;
            valid_q <= 1'b1;
          end
        end
        GRANT: begin
          // A normal release outranks the timeout in the same cycle.
          if (done || !req[sel_q]) begin
            state_q <= REL;
            valid_q <= 1'b0;
            last_q  <= sel_q;
          end else if (hold_limit) begin
            state_q   <= REL;
            valid_q   <= 1'b0;
            last_q    <= sel_q;
            timeout_q <= 1'b1;
          end
        end
        REL:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel     = sel_q;
  assign valid   = valid_q;
  assign gnt     = valid_q ? dec_y : '0;
  assign timeout = timeout_q;

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
Round-robin arbiter sharing one 3-bit select bus, and the 3-to-8 decoder it drives, among 8 requesters.
- Picks one requester per cycle and drives its index on `sel`.
- Holds the grant until the owner releases it.
- Presents a one-hot `gnt` (decoded `sel`) plus `valid`.
- Sits between the requesting blocks and the `decoder` datapath, sequencing ownership of the select lines.

Parameters:
- N, 8, number of requesters; must equal 2**SEL_W.
- SEL_W, 3, select width fed to the decoder.
- HOLD_MAX, 16, maximum grant length in cycles; used only with TIMEOUT_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, level-sensitive, bit i = requester i.
- done  input  1  one-cycle release pulse from the current owner.
- sel  output  SEL_W  index of the current owner; goes to the decoder `s` input.
- gnt  output  N  one-hot grant, equal to decode(sel) when valid=1, else 0.
- valid  output  1  a grant is active.
- timeout  output  1  one-cycle forced-release pulse; tied 0 without TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=0, gnt=0, valid=0, timeout=0.
  - last=N-1, so requester 0 has first priority.
  - Reset mid-grant drops gnt/valid immediately, without waiting for a clock edge.
- States: IDLE, GRANT, REL. All outputs are registered.
- IDLE:
  - If req != 0, search from (last+1) mod N upward, wrapping, and take the first set bit k.
  - Next edge: state=GRANT, sel=k, gnt=1<<k, valid=1.
  - Latency is 1 cycle from req sampled to gnt.
  - If req == 0, stay in IDLE with gnt=0. `sel` holds its last value.
- GRANT:
  - Hold sel/gnt while req[sel]=1 and done=0.
  - Release on done=1 or req[sel]=0. Next edge: state=REL, gnt=0, valid=0, last=sel.
- REL:
  - Mandatory single dead cycle, guaranteeing decoder settle and no back-to-back overlap.
  - Next edge: IDLE.
  - Minimum grant-to-grant spacing is therefore 2 idle cycles.
- done in IDLE or REL is ignored.
- done together with a new req in the same cycle: release first; the new request is arbitrated in the next IDLE.
- Bits of req that change during GRANT have no effect until the next IDLE.
- Wrap-around: last=N-1 makes the search start at 0. A lone requester equal to last is still granted, after a full wrap of the search.
- Arithmetic: pointer arithmetic is modulo N on SEL_W bits; no wider intermediates are needed.

Optional Feature:
- Macro: RR_DECODE_ARBITER_TIMEOUT_EN.
- With the macro:
  - A hold counter of width clog2(HOLD_MAX+1) clears on entering GRANT and increments every GRANT cycle.
  - When it reaches HOLD_MAX with no release, the next edge forces GRANT->REL, sets last=sel, and pulses timeout=1 for 1 cycle.
  - A normal release in the same cycle the limit is reached takes priority: no timeout pulse.
- Without the macro: no counter is built, timeout is tied to 0, and a grant may be held indefinitely.

Decomposition:
- Shared package/header `arb_pkg`:
  - state encodings IDLE=2'd0, GRANT=2'd1, REL=2'd2;
  - defaults for N and SEL_W;
  - HOLD_MAX default.
- One natural sub-module, `rr_pick`: purely combinational. Inputs req and last; outputs found and idx (next index in round-robin order).
- The one-hot gnt is produced by the existing `decoder` module instance driven by sel, gated by valid.

Test Plan:
- Reset: rst_n=0 with req=8'hFF → sel=0, gnt=8'h00, valid=0, timeout=0, held until the first edge after rst_n=1.
- Single request: req=8'h01 → gnt=8'h01, sel=0 one edge later. done pulse → gnt=0 next edge, then REL, then IDLE.
- Fairness: req=8'hFF held, done pulsed 2 cycles after each grant → sel sequence 0,1,...,7,0 with gnt one-hot and 2 dead cycles between grants.
- Wrap search: owner 2 releases, then req=8'b1000_0010 → grant 7 (search order 3..7), then 1 on the following arbitration.
- Async reset mid-grant: owner 5, rst_n pulled low between edges → gnt=0 immediately. After release with req=8'hFF → first grant is 0.
- TIMEOUT_EN with HOLD_MAX=4: req=8'h08 held, no done → gnt=8'h08 for 4 cycles, then timeout=1 for one cycle and gnt=0. The next grant with req=8'h09 is 0, since requester 3 just timed out.
